// File: rtl/kyber_pkg.sv
// Shared Kyber NTT datapath constants.
package kyber_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned COEFF_W = 12;
  // One extra bit so that u + t and u - t fit without loss.
  localparam int unsigned INTER_W = COEFF_W + 1;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/ntt_operand_fifo.sv
// Small circular buffer holding butterfly operands until their product returns.
module ntt_operand_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  // Storage array; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_WIDTH'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/ntt_butterfly_addsub.sv
// Cooley-Tukey butterfly add/sub stage: pairs buffered u with returned t = w*b mod q.
module ntt_butterfly_addsub
  import kyber_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = COEFF_W,
  parameter int unsigned MODULUS    = KYBER_Q,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  u_valid,
  input  logic [DATA_WIDTH-1:0] u_in,
  input  logic                  t_valid,
  input  logic [DATA_WIDTH-1:0] t_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  u_full,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] u_head;
  logic [SUM_W-1:0]      sum, diff;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // A pop frees a slot in the same cycle, so a push into a full buffer is accepted then.
  assign pop  = t_valid & enable & ~fifo_empty;
  assign push = u_valid & enable & (~fifo_full | pop);

  ntt_operand_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (u_in),
    .rd_data_c (u_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Modular add/sub at one extra bit; diff's top bit is the sign of u - t.
  always_comb begin
    sum         = SUM_W'(u_head) + SUM_W'(t_in);
    diff        = SUM_W'(u_head) - SUM_W'(t_in);
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (enable) begin
      out_valid_d = pop;
      if (pop) begin
        x_d = (sum >= SUM_W'(MODULUS)) ? DATA_WIDTH'(sum - SUM_W'(MODULUS)) : DATA_WIDTH'(sum);
        y_d = diff[SUM_W-1] ? DATA_WIDTH'(diff + SUM_W'(MODULUS)) : DATA_WIDTH'(diff);
      end
      if (u_valid & fifo_full & ~pop) ovf_d = 1'b1;
      if (t_valid & fifo_empty)       unf_d = 1'b1;
    end
  end

  // Output register and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign x_out         = x_q;
  assign y_out         = y_q;
  assign u_full        = fifo_full;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule
